// File: rtl/debounce_edge_det.sv
// debounce_edge_det: glitch filter for a synchronised level with one-cycle
// rise/fall pulses on every change of the filtered level.
// Optional feature macro: DEBOUNCE_GLITCH_CNT_EN adds the saturating
// glitch_cnt output that counts aborted transitions.
module debounce_edge_det #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                din,
  output logic                dout,
  output logic                rise,
  output logic                fall
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  // Elaboration-time parameter range check
  generate
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
      $fatal(1, "debounce_edge_det: CNT_W out of range");
    end
    if (GLITCH_W < 1 || GLITCH_W > 32) begin : g_bad_glitch_w
      $fatal(1, "debounce_edge_det: GLITCH_W out of range");
    end
    if (STABLE_CYCLES < 1 || 64'(STABLE_CYCLES) > CNT_MAX) begin : g_bad_stable
      $fatal(1, "debounce_edge_det: STABLE_CYCLES out of range");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE_LOW   = 2'd0,
    CHECK_HIGH = 2'd1,
    IDLE_HIGH  = 2'd2,
    CHECK_LOW  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dout;
  logic             r_rise;
  logic             r_fall;

  // Debounce FSM: counts consecutive samples at the opposite level and
  // commits the new level (with a pulse) on the STABLE_CYCLES-th sample
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_dout  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        IDLE_LOW: begin
          r_cnt <= '0;
          if (din) begin
            if (STABLE_CYCLES == 1) begin
              r_state <= IDLE_HIGH;
              r_dout  <= 1'b1;
              r_rise  <= 1'b1;
            end else begin
              r_state <= CHECK_HIGH;
              r_cnt   <= CNT_W'(1);
            end
          end
        end
        CHECK_HIGH: begin
          if (!din) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= IDLE_HIGH;
            r_cnt   <= '0;
            r_dout  <= 1'b1;
            r_rise  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        IDLE_HIGH: begin
          r_cnt <= '0;
          if (!din) begin
            if (STABLE_CYCLES == 1) begin
              r_state <= IDLE_LOW;
              r_dout  <= 1'b0;
              r_fall  <= 1'b1;
            end else begin
              r_state <= CHECK_LOW;
              r_cnt   <= CNT_W'(1);
            end
          end
        end
        CHECK_LOW: begin
          if (din) begin
            r_state <= IDLE_HIGH;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_dout  <= 1'b0;
            r_fall  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE_LOW;
          r_cnt   <= '0;
          r_dout  <= 1'b0;
        end
      endcase
    end
  end

  assign dout = r_dout;
  assign rise = r_rise;
  assign fall = r_fall;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic                w_abort;
  logic [GLITCH_W-1:0] r_glitch_cnt;

  // An abort is a return to the committed level before the count completed
  assign w_abort = ((r_state == CHECK_HIGH) && !din) ||
                   ((r_state == CHECK_LOW)  &&  din);

  // Saturating aborted-transition counter, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_glitch_cnt <= '0;
    end else if (w_abort && (r_glitch_cnt != {GLITCH_W{1'b1}})) begin
      r_glitch_cnt <= r_glitch_cnt + GLITCH_W'(1);
    end
  end

  assign glitch_cnt = r_glitch_cnt;
`endif

endmodule
